clk_rst_sequencer: RTL and testbench

Power-up and re-lock sequencer for the iCE40 oscillator/PLL clocking path. It runs on the free-running oscillator clock and drives the PLL reset. It waits for a stable PLL lock, with timeout and bounded retries, before releasing the system reset to the SoC. It monitors lock during operation, re-sequences on lock loss or software request, and latches a fault when retries are exhausted.

---
 rtl/clk_rst_sequencer.sv | 119 +++++++++++
 tb/tb_clk_rst_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_sequencer.sv
// Oscillator-domain PLL power-up / re-lock sequencer.
// Holds the SoC in reset until the PLL lock has been stable, retries on timeout.
module clk_rst_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 1024,
    parameter int STABLE_CYCLES  = 64,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             pll_lock,
    input  logic                             relock_req,
    output logic                             pll_resetb,
    output logic                             sys_reset,
    output logic                             ready,
    output logic                             fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);

    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ?
                            PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAXC   = (MAX_AB > STABLE_CYCLES) ?
                            MAX_AB : STABLE_CYCLES;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int RW     = $clog2(MAX_RETRIES+1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t        r_state;
    state_t        w_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_sync1;
    logic          r_sync2;
    logic          w_relock;
    logic          w_tmo;
    logic          w_last_try;

    assign w_relock   = relock_req &&
                        (r_state == S_RUN || r_state == S_FAULT);
    assign w_tmo      = (r_state == S_WAIT_LOCK) && !r_sync2 &&
                        (r_cnt == CW'(LOCK_TIMEOUT-1));
    assign w_last_try = (retry_count == RW'(MAX_RETRIES));

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_PLL_RST: begin
                if (r_cnt == CW'(PLL_RST_CYCLES-1))
                    w_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (r_sync2)
                    w_nxt = S_STABLE;
                else if (w_tmo)
                    w_nxt = w_last_try ? S_FAULT : S_PLL_RST;
            end
            S_STABLE: begin
                if (!r_sync2)
                    w_nxt = S_WAIT_LOCK;
                else if (r_cnt == CW'(STABLE_CYCLES-1))
                    w_nxt = S_RUN;
            end
            S_RUN: begin
                // A software request wins over a simultaneous lock loss.
                if (w_relock)
                    w_nxt = S_PLL_RST;
                else if (!r_sync2)
                    w_nxt = S_WAIT_LOCK;
            end
            S_FAULT: begin
                if (w_relock)
                    w_nxt = S_PLL_RST;
            end
            default: w_nxt = S_PLL_RST;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            retry_count <= '0;
            pll_resetb  <= 1'b0;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            r_sync1 <= pll_lock;
            r_sync2 <= r_sync1;
            r_state <= w_nxt;

            if (w_nxt != r_state)
                r_cnt <= '0;
            else if (r_state == S_PLL_RST || r_state == S_WAIT_LOCK ||
                     r_state == S_STABLE)
                r_cnt <= r_cnt + 1'b1;

            if (w_relock)
                retry_count <= '0;
            else if (w_tmo && !w_last_try)
                retry_count <= retry_count + 1'b1;

            // Outputs follow the next state so they change with it.
            pll_resetb <= !(w_nxt == S_PLL_RST || w_nxt == S_FAULT);
            sys_reset  <= (w_nxt != S_RUN);
            ready      <= (w_nxt == S_RUN);
            fault      <= (w_nxt == S_FAULT);
        end
    end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Bench for clk_rst_sequencer: duration-based reference model
// compared every cycle, plus directed literal edge checks.
module tb_clk_rst_sequencer;

    localparam int PRC = 16;
    localparam int LTO = 1024;
    localparam int STC = 64;
    localparam int MXR = 3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       pll_lock = 1'b1;
    logic       relock_req = 1'b0;
    logic       pll_resetb;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;

    int total = 0;
    int bad   = 0;

    clk_rst_sequencer #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LTO),
        .STABLE_CYCLES (STC),
        .MAX_RETRIES   (MXR)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .pll_lock   (pll_lock),
        .relock_req (relock_req),
        .pll_resetb (pll_resetb),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Phases of the sequence, tracked by time spent in each.
    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;
    localparam int P_FLT  = 4;

    int phase = P_RST;
    int spent = 0;
    int retries = 0;
    bit hist[2] = '{1'b0, 1'b0};

    always @(posedge CLK) begin
        int  np;
        bit  seen;
        if (RESET) begin
            phase = P_RST;
            spent = 0;
            retries = 0;
            hist = '{1'b0, 1'b0};
        end else begin
            seen = hist[1];
            np = phase;
            if (phase == P_RST) begin
                if (spent + 1 == PRC) np = P_WAIT;
            end else if (phase == P_WAIT) begin
                if (seen) np = P_STAB;
                else if (spent + 1 == LTO) begin
                    if (retries == MXR) np = P_FLT;
                    else begin
                        retries++;
                        np = P_RST;
                    end
                end
            end else if (phase == P_STAB) begin
                if (!seen) np = P_WAIT;
                else if (spent + 1 == STC) np = P_RUN;
            end else if (phase == P_RUN) begin
                if (relock_req) begin
                    np = P_RST;
                    retries = 0;
                end else if (!seen) np = P_WAIT;
            end else begin
                if (relock_req) begin
                    np = P_RST;
                    retries = 0;
                end
            end
            spent = (np != phase) ? 0 : spent + 1;
            phase = np;
            hist[1] = hist[0];
            hist[0] = pll_lock;
        end
    end

    always @(posedge CLK) begin
        #1;
        chk("m_resetb", int'(pll_resetb),
            int'(!(phase == P_RST || phase == P_FLT)));
        chk("m_sysrst", int'(sys_reset), int'(phase != P_RUN));
        chk("m_ready", int'(ready), int'(phase == P_RUN));
        chk("m_fault", int'(fault), int'(phase == P_FLT));
        chk("m_retry", int'(retry_count), retries);
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_resetb"}, int'(pll_resetb), 0);
        chk({tag, "_sysrst"}, int'(sys_reset), 1);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_fault"}, int'(fault), 0);
        chk({tag, "_retry"}, int'(retry_count), 0);
    endtask

    task automatic pulse_relock();
        relock_req = 1'b1;
        adv(1);
        relock_req = 1'b0;
    endtask

    initial begin
        adv(3);
        chk_reset_vals("rst");
        RESET = 1'b0;
        adv(15);
        chk("nom_resetb15", int'(pll_resetb), 0);
        adv(1);
        chk("nom_resetb16", int'(pll_resetb), 1);
        adv(64);
        chk("nom_ready80", int'(ready), 0);
        chk("nom_sysrst80", int'(sys_reset), 1);
        adv(1);
        chk("nom_ready81", int'(ready), 1);
        chk("nom_sysrst81", int'(sys_reset), 0);
        chk("nom_fault", int'(fault), 0);
        chk("nom_retry", int'(retry_count), 0);

        adv(10);
        pll_lock = 1'b0;
        adv(2);
        chk("loss_sysrst2", int'(sys_reset), 0);
        adv(1);
        chk("loss_sysrst3", int'(sys_reset), 1);
        chk("loss_ready3", int'(ready), 0);
        adv(2);
        pll_lock = 1'b1;
        adv(66);
        chk("loss_ready66", int'(ready), 0);
        adv(1);
        chk("loss_ready67", int'(ready), 1);
        chk("loss_retry", int'(retry_count), 0);

        adv(5);
        pll_lock = 1'b0;
        adv(2);
        pulse_relock();
        chk("prio_resetb", int'(pll_resetb), 0);
        chk("prio_sysrst", int'(sys_reset), 1);
        pll_lock = 1'b1;
        adv(81);
        chk("prio_ready", int'(ready), 1);

        adv(4);
        pulse_relock();
        chk("gl_resetb0", int'(pll_resetb), 0);
        adv(40);
        pll_lock = 1'b0;
        adv(1);
        pll_lock = 1'b1;
        adv(40);
        chk("gl_ready81", int'(ready), 0);
        chk("gl_sysrst81", int'(sys_reset), 1);
        adv(26);
        chk("gl_ready107", int'(ready), 0);
        adv(1);
        chk("gl_ready108", int'(ready), 1);
        chk("gl_retry", int'(retry_count), 0);

        pll_lock = 1'b0;
        pulse_relock();
        adv(30);
        chk("mid_resetb", int'(pll_resetb), 1);
        RESET = 1'b1;
        adv(1);
        chk_reset_vals("mid");
        RESET = 1'b0;
        pll_lock = 1'b1;
        adv(5);
        pulse_relock();
        adv(9);
        chk("ign_resetb15", int'(pll_resetb), 0);
        adv(1);
        chk("ign_resetb16", int'(pll_resetb), 1);
        adv(64);
        chk("ign_ready80", int'(ready), 0);
        adv(1);
        chk("ign_ready81", int'(ready), 1);
        chk("ign_sysrst81", int'(sys_reset), 0);

        pll_lock = 1'b0;
        RESET = 1'b1;
        adv(2);
        RESET = 1'b0;
        adv(1039);
        chk("rt_retry1039", int'(retry_count), 0);
        adv(1);
        chk("rt_retry1040", int'(retry_count), 1);
        chk("rt_resetb1040", int'(pll_resetb), 0);
        adv(1040);
        chk("rt_retry2080", int'(retry_count), 2);
        adv(1040);
        chk("rt_retry3120", int'(retry_count), 3);
        adv(1039);
        chk("rt_fault4159", int'(fault), 0);
        chk("rt_resetb4159", int'(pll_resetb), 1);
        adv(1);
        chk("rt_fault4160", int'(fault), 1);
        chk("rt_resetb4160", int'(pll_resetb), 0);
        chk("rt_sysrst4160", int'(sys_reset), 1);
        chk("rt_retry4160", int'(retry_count), 3);
        adv(100);
        chk("rt_fault_hold", int'(fault), 1);
        chk("rt_resetb_hold", int'(pll_resetb), 0);
        chk("rt_sysrst_hold", int'(sys_reset), 1);

        pll_lock = 1'b1;
        adv(5);
        pulse_relock();
        chk("rec_fault", int'(fault), 0);
        chk("rec_retry", int'(retry_count), 0);
        adv(80);
        chk("rec_ready80", int'(ready), 0);
        adv(1);
        chk("rec_ready81", int'(ready), 1);

        adv(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
